// File: rtl/sme_add_sched_pkg.sv
// Shared types and constants for the SME masked-adder scheduler.
//  sme_sched_st_t : scheduler FSM states
//  SME_KS_LAT     : number of enabled cycles the masked Kogge-Stone adder needs
package sme_add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } sme_sched_st_t;

  localparam int SME_KS_LAT = 5;

endpackage

// File: rtl/sme_add_sched_if.sv
// Bundle between the SME issue logic, the scheduler and the shared adder.
//  req_*  : R requesters, D Boolean shares per operand, packed [(r*D+s)*N +: N]
//  add_*  : link to the shared masked adder (rng_valid comes from the adder's RNG)
//  rsp_*  : single tagged response channel
//  master : issue side + adder side (drives requests, adder results, rsp_ready)
//  slave  : the scheduler
interface sme_add_sched_if #(
  parameter int D  = 3,
  parameter int N  = 32,
  parameter int R  = 2,
  parameter int IW = (R > 1) ? $clog2(R) : 1
);
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  logic [R-1:0]     req_sub;
  logic [R*D*N-1:0] req_mxor;
  logic [R*D*N-1:0] req_mand;
  logic             rng_valid;
  logic             add_en;
  logic             add_sub;
  logic [D*N-1:0]   add_mxor;
  logic [D*N-1:0]   add_mand;
  logic [D*N-1:0]   add_rd;
  logic             add_rdy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [D*N-1:0]   rsp_rd;

  modport master (
    output req_valid, req_sub, req_mxor, req_mand, rng_valid, add_rd, add_rdy, rsp_ready,
    input  req_ready, add_en, add_sub, add_mxor, add_mand, rsp_valid, rsp_id, rsp_rd
  );

  modport slave (
    input  req_valid, req_sub, req_mxor, req_mand, rng_valid, add_rd, add_rdy, rsp_ready,
    output req_ready, add_en, add_sub, add_mxor, add_mand, rsp_valid, rsp_id, rsp_rd
  );
endinterface

// File: rtl/sme_add_sched_rr_arb.sv
// sme_rr_arb: combinational round-robin arbiter shared by SME resource schedulers.
//  i_req    in  R   request vector
//  i_ptr    in  IW  highest-priority requester index
//  o_gnt    out R   one-hot grant (zero when no request)
//  o_gnt_id out IW  index of granted requester
//  o_any    out 1   at least one request present
module sme_rr_arb #(
  parameter int R  = 2,
  parameter int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [R-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_id,
  output logic          o_any
);

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    o_any    = 1'b0;
    // Scan from the farthest offset back towards i_ptr so the nearest
    // requester at/after the pointer is the last one written, i.e. wins.
    for (int k = R - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % R]) begin
        o_gnt_id = IW'((int'(i_ptr) + k) % R);
        o_any    = 1'b1;
      end
    end
    for (int k = 0; k < R; k++) o_gnt[k] = o_any && (int'(o_gnt_id) == k);
  end

endmodule

// File: rtl/sme_add_sched.sv
// sme_add_sched: shares one masked Kogge-Stone adder between R requesters.
//  g_clk     in  global clock
//  g_resetn  in  synchronous active-low reset
//  bus       slave modport of sme_add_sched_if (requests, adder link, response)
// Flow: IDLE grants round-robin and latches the winner's shares, BUSY drives the
// adder (enable gated by RNG availability) until add_rdy, RESP holds the tagged
// result until accepted. Shares are stored, muxed and cleared individually and are
// never combined with each other here.
module sme_add_sched
  import sme_add_sched_pkg::*;
#(
  parameter int D  = 3,
  parameter int N  = 32,
  parameter int R  = 2,
  parameter int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  sme_add_sched_if.slave bus
);

  sme_sched_st_t         r_st;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_id;
  logic                  r_sub;
  logic [D-1:0][N-1:0]   r_mxor;
  logic [D-1:0][N-1:0]   r_mand;
  logic [D-1:0][N-1:0]   r_res;

  logic [R-1:0]          w_gnt;
  logic [IW-1:0]         w_gid;
  logic                  w_any;
  logic                  w_idle, w_busy, w_resp;

  assign w_idle = (r_st == IDLE);
  assign w_busy = (r_st == BUSY);
  assign w_resp = (r_st == RESP);

  sme_rr_arb #(.R(R), .IW(IW)) u_arb (
    .i_req    (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gid),
    .o_any    (w_any)
  );

  assign bus.req_ready = w_idle ? w_gnt : '0;
  // Dropping en on the add_rdy cycle keeps the adder from starting a new pass.
  assign bus.add_en    = w_busy & bus.rng_valid & ~bus.add_rdy;
  assign bus.add_sub   = w_busy & r_sub;
  // Operand regs are zero outside BUSY, so no extra gating is needed.
  assign bus.add_mxor  = r_mxor;
  assign bus.add_mand  = r_mand;
  assign bus.rsp_valid = w_resp;
  assign bus.rsp_id    = w_resp ? r_id : '0;
  assign bus.rsp_rd    = r_res;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_st   <= IDLE;
      r_ptr  <= '0;
      r_id   <= '0;
      r_sub  <= 1'b0;
      r_mxor <= '0;
      r_mand <= '0;
      r_res  <= '0;
    end else begin
      case (r_st)
        IDLE: if (w_any) begin
          r_id  <= w_gid;
          r_sub <= bus.req_sub[w_gid];
          for (int s = 0; s < D; s++) begin
            r_mxor[s] <= bus.req_mxor[(int'(w_gid) * D + s) * N +: N];
            r_mand[s] <= bus.req_mand[(int'(w_gid) * D + s) * N +: N];
          end
          r_st <= BUSY;
        end
        BUSY: if (bus.add_rdy) begin
          for (int s = 0; s < D; s++) begin
            r_res[s]  <= bus.add_rd[s * N +: N];
            r_mxor[s] <= '0;
            r_mand[s] <= '0;
          end
          r_sub <= 1'b0;
          r_st  <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          for (int s = 0; s < D; s++) r_res[s] <= '0;
          r_ptr <= (r_id == IW'(R - 1)) ? '0 : r_id + 1'b1;
          r_st  <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_add_sched.sv
// Bench for sme_add_sched with a behavioural masked adder (SME_KS_LAT enabled
// cycles, fresh random output masks). Expected results go into a scoreboard
// queue at grant time and are compared when the response handshake completes.
module tb_sme_add_sched;
  import sme_add_sched_pkg::*;

  localparam int D = 3, N = 32, R = 2, IW = 1;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  sme_add_sched_if #(.D(D), .N(N), .R(R), .IW(IW)) bus ();

  sme_add_sched #(.D(D), .N(N), .R(R), .IW(IW)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  int errs = 0, nchk = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] unmask(input logic [D*N-1:0] v);
    logic [N-1:0] x = '0;
    for (int s = 0; s < D; s++) x ^= v[s*N +: N];
    return x;
  endfunction

  function automatic logic [D*N-1:0] share(input logic [N-1:0] v);
    logic [D*N-1:0] o;
    logic [N-1:0]   x = v;
    o = '0;
    for (int s = 1; s < D; s++) begin
      o[s*N +: N] = N'($urandom);
      x ^= o[s*N +: N];
    end
    o[N-1:0] = x;
    return o;
  endfunction

  function automatic logic [N-1:0] calc(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    return s ? a - b : a + b;
  endfunction

  // ---- behavioural masked adder ----
  int                  a_cnt;
  logic                spur;
  logic [D-1:0][N-1:0] amask;
  logic [N-1:0]        m_res, m_x;

  always @(posedge g_clk) begin
    for (int s = 0; s < D; s++) amask[s] <= N'($urandom);
    if (!g_resetn || bus.add_rdy) a_cnt <= 0;
    else if (bus.add_en)          a_cnt <= a_cnt + 1;
  end

  assign bus.add_rdy = (a_cnt == SME_KS_LAT) || spur;

  always_comb begin
    m_res = calc(unmask(bus.add_mxor), unmask(bus.add_mand), bus.add_sub);
    m_x   = m_res;
    bus.add_rd = '0;
    for (int s = 1; s < D; s++) begin
      bus.add_rd[s*N +: N] = amask[s];
      m_x ^= amask[s];
    end
    bus.add_rd[N-1:0] = m_x;
  end

  // ---- scoreboard ----
  typedef struct {
    int           id;
    logic [N-1:0] res;
  } exp_t;

  exp_t         sb[$];
  int           glog[$];
  logic [N-1:0] op_a[R], op_b[R];
  logic         op_s[R];
  logic [N-1:0] last_res, cur_a, cur_b;
  int           last_id = -1;
  int           rsp_cnt = 0;

  initial forever begin
    exp_t e;
    @(negedge g_clk);
    if (g_resetn) begin
      if (|bus.req_ready) begin
        chk("gnt_onehot", $countones(bus.req_ready), 1);
        for (int r = 0; r < R; r++) if (bus.req_ready[r]) begin
          chk("gnt_has_req", bus.req_valid[r], 1);
          e.id  = r;
          e.res = calc(op_a[r], op_b[r], op_s[r]);
          sb.push_back(e);
          glog.push_back(r);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_rd", unmask(bus.rsp_rd), e.res);
          last_res = unmask(bus.rsp_rd);
          last_id  = int'(bus.rsp_id);
          rsp_cnt++;
        end
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic next();
    @(posedge g_clk); #1;
  endtask

  task automatic set_req(input int r, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    op_a[r] = a; op_b[r] = b; op_s[r] = s;
    bus.req_mxor[r*D*N +: D*N] = share(a);
    bus.req_mand[r*D*N +: D*N] = share(b);
    bus.req_sub[r]   = s;
    bus.req_valid[r] = 1'b1;
  endtask

  // Called just after a posedge; returns at the negedge of the accept cycle.
  task automatic issue(input int r, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    logic [R-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    set_req(r, a, b, s);
    cur_a = a; cur_b = b;
    @(negedge g_clk);
    chk("gnt", bus.req_ready, oh);
  endtask

  // From the accept-cycle negedge, follows the op until rsp_valid rises.
  task automatic wait_rsp(input int exp_lat);
    int c = 0, en = 0;
    while (!bus.rsp_valid && c < 40) begin
      @(posedge g_clk); #1;
      if (c == 0) bus.req_valid = '0;
      @(negedge g_clk);
      c++;
      if (bus.add_en) en++;
      if (!bus.rng_valid) chk("stall_en", bus.add_en, 0);
      if (!bus.rsp_valid) begin
        chk("opnd_a", unmask(bus.add_mxor), cur_a);
        chk("opnd_b", unmask(bus.add_mand), cur_b);
      end
    end
    chk("latency", c, exp_lat);
    chk("en_cycles", en, SME_KS_LAT);
    chk("opnd_zeroed", |{bus.add_mxor, bus.add_mand, bus.add_sub}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g;
    bus.req_valid = '0; bus.req_sub = '0; bus.req_mxor = '0; bus.req_mand = '0;
    bus.rng_valid = 1'b1; bus.rsp_ready = 1'b1; spur = 1'b0;

    // reset state
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_add_en", bus.add_en, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_opnd", |{bus.add_mxor, bus.add_mand, bus.add_sub}, 0);
    chk("rst_rsp", |{bus.rsp_rd, bus.rsp_id}, 0);
    next();
    g_resetn = 1'b1;
    next();

    // 1: single add from r0
    issue(0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_rsp(7);
    next();
    chk("t1_res", last_res, 32'h0000_0008);
    chk("t1_id", last_id, 0);

    // 2: subtract from r1
    issue(1, 32'h0000_0000, 32'h0000_0001, 1'b1);
    wait_rsp(7);
    next();
    chk("t2_res", last_res, 32'hFFFF_FFFF);
    chk("t2_id", last_id, 1);

    // 3: both requesters continuously valid -> alternating grants
    glog.delete();
    base = rsp_cnt;
    set_req(0, 32'h1111_0000, 32'h0000_2222, 1'b0);
    set_req(1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    for (int k = 0; k < 200 && (rsp_cnt - base) < 4; k++) @(posedge g_clk);
    #1 bus.req_valid = '0;
    chk("t3_rsp_cnt", rsp_cnt - base, 4);
    chk("t3_gnt_cnt", glog.size(), 4);
    for (int k = 0; k < 4; k++) begin
      g = (k < glog.size()) ? glog[k] : -1;
      chk("t3_gnt_order", g, k % 2);
    end
    next();

    // 4: rng_valid low for 3 cycles mid-BUSY
    issue(1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    fork
      begin
        next(); next();
        bus.rng_valid = 1'b0;
        next(); next(); next();
        bus.rng_valid = 1'b1;
      end
      wait_rsp(10);
    join
    next();
    chk("t4_res", last_res, 32'h2222_2221);

    // 5: response back-pressure for 4 cycles
    bus.rsp_ready = 1'b0;
    issue(0, 32'hDEAD_BEEF, 32'h0000_1111, 1'b1);
    wait_rsp(7);
    set_req(1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge g_clk);
      chk("hold_vld", bus.rsp_valid, 1);
      chk("hold_id", bus.rsp_id, 0);
      chk("hold_rd", unmask(bus.rsp_rd), 32'hDEAD_ADDE);
      chk("hold_rdy", bus.req_ready, 0);
    end
    next();
    bus.rsp_ready = 1'b1;
    @(negedge g_clk);
    chk("t5_rdy_in_resp", bus.req_ready, 0);
    @(negedge g_clk);
    chk("t5_next_gnt", bus.req_ready, 2'b10);
    cur_a = 32'h0000_00FF; cur_b = 32'h0000_0001;
    wait_rsp(7);
    next();
    chk("t5_res", last_res, 32'h0000_0100);

    // 6: reset in the middle of BUSY abandons the op
    base = rsp_cnt;
    issue(0, 32'h0000_0100, 32'h0000_0010, 1'b0);
    next();
    bus.req_valid = '0;
    next(); next();
    g_resetn = 1'b0;
    sb.delete();
    @(negedge g_clk);
    @(negedge g_clk);
    chk("t6_add_en", bus.add_en, 0);
    chk("t6_rsp_valid", bus.rsp_valid, 0);
    chk("t6_opnd", |{bus.add_mxor, bus.add_mand, bus.add_sub}, 0);
    chk("t6_rsp", |{bus.rsp_rd, bus.rsp_id}, 0);
    next();
    g_resetn = 1'b1;
    chk("t6_no_rsp", rsp_cnt - base, 0);
    next();
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_rsp(7);
    next();
    chk("t6_res", last_res, 32'h0000_0000);

    // 7: stray add_rdy while IDLE must be ignored
    spur = 1'b1;
    @(negedge g_clk);
    chk("t7_add_en", bus.add_en, 0);
    next();
    spur = 1'b0;
    @(negedge g_clk);
    chk("t7_rsp_valid", bus.rsp_valid, 0);
    next();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
